ln_variance_feeder: RTL and testbench

// Producer side of the LN stage-1 variance accumulator interface.
// - Per accepted beat: takes TOUT channel lanes of one token plus that token's mean.
// - Forms the saturated deviations (x-mean), squares them, and sums the squares

---
 rtl/ln_variance_feeder_if.sv | 14 +
 rtl/ln_variance_feeder.sv | 253 +++++++++++++++++++++++++
 tb/tb_ln_variance_feeder.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ln_variance_feeder_if.sv
// Input beat bus of the LN variance feeder: one token's TOUT lanes plus its mean.
// The producer side drives the beat; the feeder answers with in_rdy.
interface ln_variance_feeder_if #(
  parameter int DAT_DW = 16,
  parameter int TOUT   = 32
);
  logic                     in_vld;
  logic                     in_rdy;
  logic [TOUT*DAT_DW-1:0]   in_x;
  logic [DAT_DW-1:0]        in_mean;

  modport master (output in_vld, output in_x, output in_mean, input in_rdy);
  modport slave  (input in_vld, input in_x, input in_mean, output in_rdy);
endinterface

// File: rtl/ln_variance_feeder.sv
// LN stage-1 variance producer: squares the saturated (x - mean) of every lane and
// sums the squares through a pipelined adder tree that feeds the variance accumulator.
module ln_variance_feeder #(
  parameter int DAT_DW    = 16,
  parameter int TOUT      = 32,
  parameter int LOG2_TOUT = 5,
  parameter int GRP_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [LOG2_TOUT:0]            cfg_tok_num,
  input  logic [GRP_W-1:0]              cfg_grp_num,
  ln_variance_feeder_if.slave           in_bus,
  output logic                          dat_vld_o,
  output logic [2*DAT_DW+LOG2_TOUT-1:0] dat_o,
  output logic                          stripe_loop_end_o,
  output logic                          ch_acc_max_now_o,
  output logic                          ch_and_stripe_loop_end_o,
  output logic                          busy,
  output logic                          done
);

  localparam int LAT   = 2 + LOG2_TOUT;
  localparam int TOK_W = LOG2_TOUT + 1;
  localparam int MAG_W = DAT_DW - 1;
  localparam int SQ_W  = 2*DAT_DW - 2;
  localparam int SUM_W = SQ_W + LOG2_TOUT;
  localparam int OUT_W = 2*DAT_DW + LOG2_TOUT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [TOK_W-1:0]   tok_num_r;
  logic [TOK_W-1:0]   tok_cnt_r;
  logic [TOK_W-1:0]   tok_num_clamp_s;
  logic [GRP_W-1:0]   grp_num_r;
  logic [GRP_W-1:0]   grp_cnt_r;
  logic [GRP_W-1:0]   grp_num_clamp_s;
  logic               in_rdy_r;
  logic               busy_r;
  logic               done_r;
  logic               accept_s;
  logic               last_tok_s;
  logic               last_grp_s;
  logic               tail_only_s;
  logic               last_leaves_s;
  logic [LAT-1:0]     vld_r;
  logic [2:0]         flg_r [LAT];
  logic [MAG_W-1:0]   mag_r [TOUT];

  // |x - m| at DAT_DW+1 bits, clamped to the symmetric range so the square stays below 2^SQ_W.
  function automatic logic [MAG_W-1:0] sat_mag(input logic [DAT_DW-1:0] x,
                                               input logic [DAT_DW-1:0] m);
    logic [DAT_DW:0] d;
    logic [DAT_DW:0] mag;
    d = {x[DAT_DW-1], x} - {m[DAT_DW-1], m};
    if (d[DAT_DW]) begin
      mag = ~d + (DAT_DW+1)'(1);
    end else begin
      mag = d;
    end
    if (mag[DAT_DW] | mag[DAT_DW-1]) begin
      sat_mag = {MAG_W{1'b1}};
    end else begin
      sat_mag = mag[MAG_W-1:0];
    end
  endfunction

  assign in_bus.in_rdy = in_rdy_r;
  assign accept_s      = in_bus.in_vld & in_rdy_r;
  assign last_tok_s    = (tok_cnt_r == (tok_num_r - TOK_W'(1)));
  assign last_grp_s    = (grp_cnt_r == (grp_num_r - GRP_W'(1)));
  // Pipe is done once only the output stage may still hold a beat; the last
  // beat is one stage short of the output exactly one cycle before that.
  assign tail_only_s   = ~|vld_r[LAT-2:0];
  assign last_leaves_s = vld_r[LAT-2] & ~|vld_r[LAT-3:0];

  // Clamp the job configuration into its legal range.
  always_comb begin
    tok_num_clamp_s = cfg_tok_num;
    grp_num_clamp_s = cfg_grp_num;
    if ((cfg_tok_num == TOK_W'(0)) || (cfg_tok_num > TOK_W'(TOUT))) begin
      tok_num_clamp_s = TOK_W'(TOUT);
    end else begin
      tok_num_clamp_s = cfg_tok_num;
    end
    if (cfg_grp_num == GRP_W'(0)) begin
      grp_num_clamp_s = GRP_W'(1);
    end else begin
      grp_num_clamp_s = cfg_grp_num;
    end
  end

  // Job state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Job sequencing: start only from IDLE, drain until the last beat reaches the output.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s && last_tok_s && last_grp_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (tail_only_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Registered status outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_rdy_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      in_rdy_r <= (state_nxt_s == ST_RUN);
      busy_r   <= (state_nxt_s != ST_IDLE);
      done_r   <= (state_r == ST_DRAIN) & last_leaves_s;
    end
  end

  // Configuration latch and token/group counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      tok_num_r <= TOK_W'(0);
      grp_num_r <= GRP_W'(0);
      tok_cnt_r <= TOK_W'(0);
      grp_cnt_r <= GRP_W'(0);
    end else if ((state_r == ST_IDLE) && start) begin
      tok_num_r <= tok_num_clamp_s;
      grp_num_r <= grp_num_clamp_s;
      tok_cnt_r <= TOK_W'(0);
      grp_cnt_r <= GRP_W'(0);
    end else if (accept_s) begin
      if (last_tok_s) begin
        tok_cnt_r <= TOK_W'(0);
        if (last_grp_s) begin
          grp_cnt_r <= GRP_W'(0);
        end else begin
          grp_cnt_r <= grp_cnt_r + GRP_W'(1);
        end
      end else begin
        tok_cnt_r <= tok_cnt_r + TOK_W'(1);
      end
    end
  end

  // Valid and flag shift registers; flags are zero on bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= {LAT{1'b0}};
      for (int k = 0; k < LAT; k++) begin
        flg_r[k] <= 3'b000;
      end
    end else begin
      vld_r <= {vld_r[LAT-2:0], accept_s};
      if (accept_s) begin
        flg_r[0] <= {last_tok_s, last_grp_s, last_tok_s & last_grp_s};
      end else begin
        flg_r[0] <= 3'b000;
      end
      for (int k = 1; k < LAT; k++) begin
        flg_r[k] <= flg_r[k-1];
      end
    end
  end

  // Difference/saturation stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TOUT; i++) begin
        mag_r[i] <= MAG_W'(0);
      end
    end else if (accept_s) begin
      for (int i = 0; i < TOUT; i++) begin
        mag_r[i] <= sat_mag(in_bus.in_x[i*DAT_DW +: DAT_DW], in_bus.in_mean);
      end
    end
  end

  // Level 0 holds the squares; each later level halves the lane count, growing one bit.
  for (genvar l = 0; l <= LOG2_TOUT; l++) begin : g_lvl
    localparam int N = TOUT >> l;
    localparam int W = SQ_W + l;
    logic [W-1:0] sum_r [N];

    if (l == 0) begin : g_sq
      // Square stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < N; i++) begin
            sum_r[i] <= W'(0);
          end
        end else if (vld_r[l]) begin
          for (int i = 0; i < N; i++) begin
            sum_r[i] <= W'(mag_r[i]) * W'(mag_r[i]);
          end
        end
      end
    end else begin : g_add
      // Adder tree level.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < N; i++) begin
            sum_r[i] <= W'(0);
          end
        end else if (vld_r[l]) begin
          for (int i = 0; i < N; i++) begin
            sum_r[i] <= W'(g_lvl[l-1].sum_r[2*i]) + W'(g_lvl[l-1].sum_r[2*i+1]);
          end
        end
      end
    end
  end

  assign dat_vld_o                = vld_r[LAT-1];
  assign dat_o                    = OUT_W'(g_lvl[LOG2_TOUT].sum_r[0]);
  assign stripe_loop_end_o        = flg_r[LAT-1][2];
  assign ch_acc_max_now_o         = flg_r[LAT-1][1];
  assign ch_and_stripe_loop_end_o = flg_r[LAT-1][0];
  assign busy                     = busy_r;
  assign done                     = done_r;

endmodule

// File: tb/tb_ln_variance_feeder.sv
// Bench for ln_variance_feeder: table vectors and hand sequences feed a scoreboard
// that checks data, flags, latency and done timing of every output beat.
module tb_ln_variance_feeder;
  localparam int DAT_DW = 16, TOUT = 32, LOG2_TOUT = 5, GRP_W = 8;
  localparam int LAT = 2 + LOG2_TOUT;
  localparam int OUT_W = 2*DAT_DW + LOG2_TOUT;
  localparam int SMAX = (1 << (DAT_DW-1)) - 1;

  typedef struct { logic [DAT_DW-1:0] x; logic [DAT_DW-1:0] mean; longint exp; } vec_t;
  typedef struct { logic [OUT_W-1:0] dat; logic [2:0] flg; int due; } exp_t;

  logic clk = 1'b0;
  logic rst, start;
  logic [LOG2_TOUT:0] cfg_tok_num;
  logic [GRP_W-1:0] cfg_grp_num;
  logic dat_vld_o, sle, cam, cas, busy, done;
  logic [OUT_W-1:0] dat_o;

  ln_variance_feeder_if #(.DAT_DW(DAT_DW), .TOUT(TOUT)) bus();

  ln_variance_feeder #(.DAT_DW(DAT_DW), .TOUT(TOUT), .LOG2_TOUT(LOG2_TOUT), .GRP_W(GRP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_tok_num(cfg_tok_num), .cfg_grp_num(cfg_grp_num),
    .in_bus(bus), .dat_vld_o(dat_vld_o), .dat_o(dat_o), .stripe_loop_end_o(sle),
    .ch_acc_max_now_o(cam), .ch_and_stripe_loop_end_o(cas), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  vec_t tbl[8];
  int n_vec = 0, n_err = 0;
  int exp_done = -1;
  int m_tok, m_grp, m_tok_num, m_grp_num;

  function automatic logic [TOUT*DAT_DW-1:0] fill(input logic [DAT_DW-1:0] v);
    logic [TOUT*DAT_DW-1:0] r;
    for (int i = 0; i < TOUT; i++) r[i*DAT_DW +: DAT_DW] = v;
    return r;
  endfunction

  function automatic longint model_sum(input logic [TOUT*DAT_DW-1:0] x, input logic [DAT_DW-1:0] m);
    longint acc = 0;
    int d;
    logic signed [DAT_DW-1:0] xs, ms;
    ms = m;
    for (int i = 0; i < TOUT; i++) begin
      xs = x[i*DAT_DW +: DAT_DW];
      d = int'(xs) - int'(ms);
      if (d > SMAX) d = SMAX;
      else if (d < -SMAX) d = -SMAX;
      acc += longint'(d) * longint'(d);
    end
    return acc;
  endfunction

  task automatic start_job(input int tok, input int grp);
    cfg_tok_num = tok[LOG2_TOUT:0];
    cfg_grp_num = grp[GRP_W-1:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_tok_num = (tok == 0 || tok > TOUT) ? TOUT : tok;
    m_grp_num = (grp == 0) ? 1 : grp;
    m_tok = 0;
    m_grp = 0;
  endtask

  task automatic send_beat(input logic [TOUT*DAT_DW-1:0] x, input logic [DAT_DW-1:0] m, input longint ex);
    exp_t e;
    int k = 0;
    while (!bus.in_rdy && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_rdy) begin
      n_vec++; n_err++;
      $display("FAIL rdy_wait in_rdy=%b required=1 after %0d cycles", bus.in_rdy, k);
    end else begin
      bus.in_vld = 1'b1;
      bus.in_x = x;
      bus.in_mean = m;
      e.dat = ex[OUT_W-1:0];
      e.flg[2] = (m_tok == m_tok_num - 1);
      e.flg[1] = (m_grp == m_grp_num - 1);
      e.flg[0] = e.flg[2] & e.flg[1];
      e.due = cyc + LAT;
      if (e.flg == 3'b111) exp_done = e.due;
      sb.push_back(e);
      if (m_tok == m_tok_num - 1) begin
        m_tok = 0;
        m_grp++;
      end else begin
        m_tok++;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    bus.in_vld = 1'b0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (busy) begin
      n_err++;
      $display("FAIL %s_idle busy=%b required=0", tag, busy);
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain pending=%0d required=0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    bus.in_vld = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    exp_done = -1;
    @(negedge clk);
    n_vec++;
    if ({dat_vld_o, dat_o, sle, cam, cas, busy, done, bus.in_rdy} != '0) begin
      n_err++;
      $display("FAIL rst_outputs vld=%b dat=%0d flg=%b%b%b busy=%b done=%b rdy=%b required all 0",
               dat_vld_o, dat_o, sle, cam, cas, busy, done, bus.in_rdy);
    end
    rst = 1'b0;
  endtask

  // Output monitor: pops the scoreboard on every valid beat, checks bubbles and done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (dat_vld_o) begin
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out dat=%0d flg=%b%b%b at cycle %0d, required none", dat_o, sle, cam, cas, cyc);
        end else begin
          e = sb.pop_front();
          n_vec++;
          if (dat_o !== e.dat || {sle, cam, cas} !== e.flg || cyc != e.due) begin
            n_err++;
            $display("FAIL out_beat dat=%0d flg=%b%b%b cyc=%0d required dat=%0d flg=%b cyc=%0d",
                     dat_o, sle, cam, cas, cyc, e.dat, e.flg, e.due);
          end
        end
      end else begin
        if ({sle, cam, cas} != 3'b000) begin
          n_err++;
          $display("FAIL bubble_flags flg=%b%b%b required 000 at cycle %0d", sle, cam, cas, cyc);
        end
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          n_err++;
          $display("FAIL missing_out none at cycle %0d, required beat due %0d", cyc, sb[0].due);
          void'(sb.pop_front());
        end
      end
      if (done || cyc == exp_done) begin
        n_vec++;
        if (done !== (cyc == exp_done)) begin
          n_err++;
          $display("FAIL done_pulse done=%b at cycle %0d, required at cycle %0d", done, cyc, exp_done);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TOUT*DAT_DW-1:0] x;
    logic [DAT_DW-1:0] m;
    int seen;

    tbl[0] = '{16'h0003, 16'h0001, 64'd128};
    tbl[1] = '{16'h7FFF, 16'h8000, 64'd34357641248};
    tbl[2] = '{16'h8000, 16'h7FFF, 64'd34357641248};
    tbl[3] = '{16'h00C8, 16'hFFC8, 64'd2097152};
    tbl[4] = '{16'hFFFB, 16'h0005, 64'd3200};
    tbl[5] = '{16'h0064, 16'hFF9C, 64'd1280000};
    tbl[6] = '{16'h8000, 16'h0000, 64'd34357641248};
    tbl[7] = '{16'h7FFF, 16'h7FFF, 64'd0};

    cfg_tok_num = '0;
    cfg_grp_num = '0;
    bus.in_x = '0;
    bus.in_mean = '0;
    do_reset();

    // Uniform x=3, mean=1, in_vld held high: 8 beats of 128.
    start_job(4, 2);
    for (int i = 0; i < 8; i++) send_beat(fill(16'h0003), 16'h0001, 64'd128);
    wait_idle("uniform");

    // Table vectors, including both saturation directions.
    start_job(8, 1);
    for (int i = 0; i < 8; i++) send_beat(fill(tbl[i].x), tbl[i].mean, tbl[i].exp);
    wait_idle("table");

    // Random data with random input gaps.
    start_job(7, 3);
    for (int i = 0; i < 21; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        bus.in_vld = 1'b0;
        repeat (gap) @(negedge clk);
      end
      for (int j = 0; j < TOUT; j++) x[j*DAT_DW +: DAT_DW] = DAT_DW'($urandom);
      m = DAT_DW'($urandom);
      send_beat(x, m, model_sum(x, m));
    end
    wait_idle("random");

    // Single-beat job carries all three flags.
    start_job(1, 1);
    send_beat(fill(16'hFFF0), 16'h0010, 64'd32768);
    wait_idle("single");

    // Zero configuration clamps to TOUT tokens and one group.
    start_job(0, 0);
    for (int i = 0; i < TOUT; i++) begin
      for (int j = 0; j < TOUT; j++) x[j*DAT_DW +: DAT_DW] = DAT_DW'($urandom);
      m = DAT_DW'($urandom);
      send_beat(x, m, model_sum(x, m));
    end
    wait_idle("clamp");

    // start while running or draining is ignored.
    start_job(2, 2);
    send_beat(fill(16'h0002), 16'h0000, 64'd128);
    cfg_tok_num = 6'd5;
    cfg_grp_num = 8'd5;
    start = 1'b1;
    send_beat(fill(16'h0004), 16'h0000, 64'd512);
    start = 1'b0;
    send_beat(fill(16'h0000), 16'h0001, 64'd32);
    send_beat(fill(16'h0001), 16'h0003, 64'd128);
    bus.in_vld = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("busy_start");
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || bus.in_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL drain_start busy=%b rdy=%b required 0 0", busy, bus.in_rdy);
    end

    // Reset in the middle of a job flushes everything.
    start_job(4, 2);
    for (int i = 0; i < 3; i++) send_beat(fill(16'h0009), 16'h0002, 64'd1568);
    do_reset();
    seen = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      if (dat_vld_o || done || busy) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL flush_quiet activity=%0d cycles required 0", seen);
    end

    // A fresh job after reset runs normally.
    start_job(2, 1);
    send_beat(fill(16'h0005), 16'h0008, 64'd288);
    send_beat(fill(16'hFFFF), 16'h0001, 64'd128);
    wait_idle("after_rst");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
